// File: rtl/peripheral_adder_pkg.sv
// Shared types and helpers for the multi-lane peripheral adder pipeline.
package peripheral_adder_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_t;

  // LSB position of a lane within a flat packed bus.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/peripheral_adder_lane.sv
// One adder lane: add/sub result register, running accumulator and sticky overflow.
// Saturating arithmetic is built only when PERIPHERAL_ADDER_SAT_EN is defined.
module peripheral_adder_lane
  import peripheral_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  op_t                  op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH:0]       out_o,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  logic [WIDTH:0]       out_q, out_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic [WIDTH:0]       sum, diff, add_res, sub_res;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_res;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    // One spare bit holds the true sum; ACC_WIDTH >= WIDTH+1 guarantees it cannot overflow twice.
    acc_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
`ifdef PERIPHERAL_ADDER_SAT_EN
    add_res = sum[WIDTH]  ? {1'b0, {WIDTH{1'b1}}} : sum;
    sub_res = diff[WIDTH] ? '0 : diff;
    acc_res = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
    add_res = sum;
    sub_res = diff;
    acc_res = acc_sum[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    out_d = out_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load) begin
      unique case (op)
        OP_ADD: out_d = add_res;
        OP_SUB: out_d = sub_res;
        OP_ACC: begin
          out_d = add_res;
          acc_d = acc_res;
          ovf_d = ovf_q | acc_sum[ACC_WIDTH];
        end
        OP_CLR: begin
          out_d = '0;
          acc_d = '0;
          ovf_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_o = out_q;
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/peripheral_adder_pipe.sv
// Multi-lane registered adder/accumulator behind a valid/ready handshake (latency 1).
// Optional saturation: define PERIPHERAL_ADDER_SAT_EN.
module peripheral_adder_pipe
  import peripheral_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 2,
  parameter int unsigned ACC_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            op,
  input  logic [LANES*WIDTH-1:0]     in1,
  input  logic [LANES*WIDTH-1:0]     in2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*(WIDTH+1)-1:0] out,
  output logic [LANES*ACC_WIDTH-1:0] acc,
  output logic [LANES-1:0]           ovf
);

  logic out_valid_q, out_valid_d;
  logic accept;
  op_t  op_e;

  assign op_e     = op_t'(op);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_valid_q <= 1'b0;
    else      out_valid_q <= out_valid_d;
  end

  assign out_valid = out_valid_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    peripheral_adder_lane #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst),
      .load (accept),
      .op   (op_e),
      .a    (in1[lane_lo(i, WIDTH) +: WIDTH]),
      .b    (in2[lane_lo(i, WIDTH) +: WIDTH]),
      .out_o(out[lane_lo(i, WIDTH+1) +: WIDTH+1]),
      .acc_o(acc[lane_lo(i, ACC_WIDTH) +: ACC_WIDTH]),
      .ovf_o(ovf[i])
    );
  end

endmodule

// File: tb/tb_peripheral_adder_pipe.sv
// Scoreboard bench for peripheral_adder_pipe (16-bit and 9-bit accumulator instances).
`timescale 1ns/1ps
module tb_peripheral_adder_pipe;

`ifdef PERIPHERAL_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] in1, in2;

  logic        in_ready, out_valid;
  logic [17:0] out;
  logic [31:0] acc;
  logic [1:0]  ovf;

  logic        in_ready9, out_valid9;
  logic [17:0] out9;
  logic [17:0] acc9;
  logic [1:0]  ovf9;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    logic [17:0] out;
    logic [31:0] acc;
    logic [1:0]  ovf;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  peripheral_adder_pipe #(.WIDTH(8), .LANES(2), .ACC_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .acc(acc), .ovf(ovf)
  );

  peripheral_adder_pipe #(.WIDTH(8), .LANES(2), .ACC_WIDTH(9)) u_dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid9), .out_ready(out_ready),
    .out(out9), .acc(acc9), .ovf(ovf9)
  );

  function automatic logic [8:0] m_out(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s, d;
    s = {1'b0, a} + {1'b0, b};
    d = {1'b0, a} - {1'b0, b};
    if (SAT && s[8]) s = 9'h0FF;
    if (SAT && d[8]) d = 9'h000;
    case (o)
      2'd0, 2'd2: return s;
      2'd1:       return d;
      default:    return 9'h000;
    endcase
  endfunction

  function automatic logic [16:0] m_acc(input logic [15:0] cur, input logic [7:0] a, input logic [7:0] b);
    logic [16:0] t;
    t = {1'b0, cur} + {9'h0, a} + {9'h0, b};
    if (SAT && t[16]) t = {1'b1, 16'hFFFF};
    return t;
  endfunction

  task automatic send_beat(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op = o; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; in1 = '0; in2 = '0;
    #1;
    nchecks++;
    if ({out_valid, out_valid9, out, acc, ovf, acc9} !== '0) begin
      nerr++; $display("FAIL reset_state got ov=%b out=%h acc=%h ovf=%b acc9=%h required all zero",
                       out_valid, out, acc, ovf, acc9);
    end
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add();
    send_beat(2'd0, {8'd5, 8'd200}, {8'd3, 8'd100});
    nchecks++;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL add_valid got %b required 1", out_valid); end
    nchecks++;
    if (out !== {9'h008, (SAT ? 9'h0FF : 9'h12C)}) begin
      nerr++; $display("FAIL add_out got %h required %h", out, {9'h008, (SAT ? 9'h0FF : 9'h12C)});
    end
    nchecks++;
    if (acc !== 32'h0 || ovf !== 2'b00) begin nerr++; $display("FAIL add_acc got %h/%b required 0/00", acc, ovf); end
  endtask

  task automatic test_sub();
    send_beat(2'd1, {8'd10, 8'd3}, {8'd4, 8'd5});
    nchecks++;
    if (out !== {9'h006, (SAT ? 9'h000 : 9'h1FE)}) begin
      nerr++; $display("FAIL sub_borrow got %h required %h", out, {9'h006, (SAT ? 9'h000 : 9'h1FE)});
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 2'd0; in1 = {8'd1, 8'd2}; in2 = {8'd3, 8'd4}; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in1 = {8'd10, 8'd20}; in2 = {8'd30, 8'd40};
    for (int c = 0; c < 5; c++) begin
      #1;
      nchecks++;
      if (in_ready !== 1'b0 || in_ready9 !== 1'b0 || out_valid !== 1'b1 || out !== {9'h004, 9'h006}) begin
        nerr++; $display("FAIL stall_hold cyc %0d got rdy=%b ov=%b out=%h required 0 1 %h",
                         c, in_ready, out_valid, out, {9'h004, 9'h006});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    nchecks++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL release_ready got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    nchecks++;
    if (out_valid !== 1'b1 || out !== {9'h028, 9'h03C}) begin
      nerr++; $display("FAIL release_new got ov=%b out=%h required 1 %h", out_valid, out, {9'h028, 9'h03C});
    end
    @(posedge clk); #1;
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL drain_valid got %b required 0", out_valid); end
  endtask

  task automatic test_acc_wrap();
    logic [8:0] e_acc [3];
    logic [1:0] e_ovf [3];
    test_reset();
    e_acc[0] = 9'd510; e_acc[1] = SAT ? 9'd511 : 9'd508; e_acc[2] = SAT ? 9'd511 : 9'd506;
    e_ovf[0] = 2'b00;  e_ovf[1] = 2'b01;                 e_ovf[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      send_beat(2'd2, {8'd1, 8'd255}, {8'd2, 8'd255});
      nchecks++;
      if (acc9 !== {9'(3 * (k + 1)), e_acc[k]} || ovf9 !== e_ovf[k] || out_valid9 !== 1'b1) begin
        nerr++; $display("FAIL acc9_step%0d got acc=%h ovf=%b ov=%b required %h %b 1",
                         k, acc9, ovf9, out_valid9, {9'(3 * (k + 1)), e_acc[k]}, e_ovf[k]);
      end
      nchecks++;
      if (out9 !== {9'h003, (SAT ? 9'h0FF : 9'h1FE)}) begin
        nerr++; $display("FAIL acc9_out%0d got %h required %h", k, out9, {9'h003, (SAT ? 9'h0FF : 9'h1FE)});
      end
    end
    send_beat(2'd3, 16'hFFFF, 16'hFFFF);
    nchecks++;
    if (acc9 !== '0 || ovf9 !== 2'b00 || out9 !== '0 || acc !== '0) begin
      nerr++; $display("FAIL clr got acc9=%h ovf9=%b out9=%h acc=%h required zeros", acc9, ovf9, out9, acc);
    end
  endtask

  task automatic test_streaming();
    int accepted = 0;
    int cycles = 0;
    logic [1:0]  cop;
    logic [15:0] ca, cb;
    logic [15:0] macc [2];
    logic [1:0]  movf;
    exp_t e, g;
    test_reset();
    macc[0] = '0; macc[1] = '0; movf = '0;
    cop = 2'($urandom_range(0, 3)); ca = 16'($urandom); cb = 16'($urandom);
    while (accepted < 100 && cycles < 2000) begin
      @(negedge clk);
      in_valid = 1'b1; op = cop; in1 = ca; in2 = cb; out_ready = 1'($urandom_range(0, 1));
      #1;
      nchecks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        nerr++; $display("FAIL stream_ready got %b required %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid === 1'b0) begin
        nchecks++;
        if (sb.size() != 0) begin nerr++; $display("FAIL stream_idle got 0 valid required pending %0d", sb.size()); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        nchecks++;
        if (sb.size() == 0) begin
          nerr++; $display("FAIL stream_extra got out=%h required no beat", out);
        end else begin
          g = sb.pop_front();
          if (out !== g.out || acc !== g.acc || ovf !== g.ovf) begin
            nerr++; $display("FAIL stream_data got %h/%h/%b required %h/%h/%b", out, acc, ovf, g.out, g.acc, g.ovf);
          end
        end
      end
      if (in_valid && (!out_valid || out_ready)) begin
        for (int l = 0; l < 2; l++) begin
          logic [16:0] t;
          e.out[l*9 +: 9] = m_out(cop, ca[l*8 +: 8], cb[l*8 +: 8]);
          t = m_acc(macc[l], ca[l*8 +: 8], cb[l*8 +: 8]);
          if (cop == 2'd2) begin macc[l] = t[15:0]; movf[l] = movf[l] | t[16]; end
          if (cop == 2'd3) begin macc[l] = '0; movf[l] = 1'b0; end
        end
        e.acc = {macc[1], macc[0]};
        e.ovf = movf;
        sb.push_back(e);
        accepted++;
        cop = 2'($urandom_range(0, 3)); ca = 16'($urandom); cb = 16'($urandom);
      end
      @(posedge clk);
      cycles++;
    end
    nchecks++;
    if (accepted != 100) begin nerr++; $display("FAIL stream_timeout got %0d beats required 100", accepted); end
    cycles = 0;
    while (sb.size() != 0 && cycles < 10) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      nchecks++;
      if (out_valid !== 1'b1) begin
        nerr++; $display("FAIL drain_missing got ov=%b required 1", out_valid);
        void'(sb.pop_front());
      end else begin
        g = sb.pop_front();
        if (out !== g.out || acc !== g.acc || ovf !== g.ovf) begin
          nerr++; $display("FAIL drain_data got %h/%h/%b required %h/%h/%b", out, acc, ovf, g.out, g.acc, g.ovf);
        end
      end
      @(posedge clk);
      cycles++;
    end
    @(negedge clk);
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL stream_end_valid got %b required 0", out_valid); end
  endtask

  task automatic test_midop_reset();
    test_reset();
    for (int k = 0; k < 9; k++) send_beat(2'd2, {8'd1, 8'd255}, {8'd1, 8'd255});
    send_beat(2'd2, {8'd1, 8'd35}, {8'd1, 8'd35});
    out_ready = 1'b0;
    nchecks++;
    if (out_valid !== 1'b1 || acc[15:0] !== 16'h1234 || acc[31:16] !== 16'd20) begin
      nerr++; $display("FAIL preload got ov=%b acc=%h required 1 %h", out_valid, acc, {16'd20, 16'h1234});
    end
    #2;
    rst = 1'b0;
    #1;
    nchecks++;
    if (out_valid !== 1'b0 || acc !== '0 || ovf !== '0 || out !== '0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL async_reset got ov=%b acc=%h ovf=%b out=%h rdy=%b required 0 0 0 0 1",
                       out_valid, acc, ovf, out, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send_beat(2'd0, {8'd7, 8'd1}, {8'd8, 8'd2});
    nchecks++;
    if (out_valid !== 1'b1 || out !== {9'h00F, 9'h003} || acc !== '0) begin
      nerr++; $display("FAIL post_reset got ov=%b out=%h acc=%h required 1 %h 0", out_valid, out, acc, {9'h00F, 9'h003});
    end
    @(posedge clk); #1;
    nchecks++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL post_reset_single got %b required 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; in1 = '0; in2 = '0;
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_acc_wrap();
    test_streaming();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/peripheral_adder_pipe.md
Name: peripheral_adder_pipe

Overview:
- Parametrised, multi-lane successor to the single registered 8-bit adder used in the peripheral datapath.
- Per lane it performs add, subtract, or accumulate, behind a valid/ready handshake with a registered output stage.
- Each lane keeps its own running accumulator with a clear op.
- Sits between a peripheral register front-end (producer) and downstream datapath/NoC packetiser (consumer).

Parameters:
- WIDTH, 8: operand width per lane.
- LANES, 2: number of independent channels processed in parallel.
- ACC_WIDTH, 16: accumulator width per lane; must be >= WIDTH+1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept beat.
- op  input  2  0=ADD, 1=SUB, 2=ACC, 3=CLR.
- in1  input  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH], unsigned.
- in2  input  LANES*WIDTH  same packing.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- out  output  LANES*(WIDTH+1)  per-lane ADD/SUB result.
- acc  output  LANES*ACC_WIDTH  per-lane accumulator value, registered.
- ovf  output  LANES  per-lane sticky accumulator overflow flag.

Behaviour:
- Reset (rst=0, async): out, acc, ovf = 0; out_valid = 0. in_ready is combinational and therefore 1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready.
  - Result appears with out_valid=1 on the next cycle (latency 1), so back-to-back throughput is 1 beat/cycle.
  - out/acc hold stable while out_valid && !out_ready.
  - out_valid falls when out_ready is high and no new beat is accepted.
- ADD: out_i = {1'b0,in1_i} + {1'b0,in2_i}; MSB is the carry. acc unchanged.
- SUB: out_i = {1'b0,in1_i} - {1'b0,in2_i}, mod 2^(WIDTH+1); MSB is the borrow/sign. acc unchanged.
- ACC:
  - acc_i <= acc_i + in1_i + in2_i, mod 2^ACC_WIDTH.
  - If the true sum >= 2^ACC_WIDTH, ovf_i <= 1; ovf is sticky.
  - out_i = ADD result.
- CLR: acc_i <= 0, ovf_i <= 0, out_i <= 0.
- Lanes are fully independent; one op applies to all lanes in a beat.
- Values are unchanged when no beat is accepted.
- Stalled output plus a new in_valid: in_ready=0, input ignored; the producer must hold.
- Simultaneous accept and drain (out_valid && out_ready && in_valid): the new result replaces the old in the same edge, and out_valid stays 1.
- Reset mid-operation: the pending result is discarded, accumulators cleared, and no out_valid is produced for pre-reset beats.

Optional Feature:
- Macro: PERIPHERAL_ADDER_SAT_EN.
- Defined:
  - ACC saturates at 2^ACC_WIDTH-1 instead of wrapping; ovf still sets.
  - ADD out_i clamps to {1'b0, all-ones WIDTH} when the carry would be 1.
  - SUB clamps to 0 on borrow.
  - Out MSB is then always 0.
- Undefined: wrap-around arithmetic as above, with no clamp logic synthesised.

Decomposition:
- Package peripheral_adder_pkg holds:
  - the op_t enum (ADD/SUB/ACC/CLR, 2 bits);
  - the OP_W=2 localparam;
  - the function for lane-slice indexing.
- Natural sub-module: peripheral_adder_lane.
  - One lane's arithmetic, accumulator, ovf, and optional saturation.
  - Instantiated LANES times via generate; it takes a shared load enable from the handshake logic in the top.

Test Plan (WIDTH=8, LANES=2, ACC_WIDTH=16 unless noted):
- Reset and ADD: rst low then high; ADD lane0 200+100, lane1 5+3, out_ready=1 -> next cycle out_valid=1, out lane0=9'h12C, lane1=9'h008; acc=0.
- SUB borrow: SUB lane0 3-5 -> out lane0=9'h1FE; with PERIPHERAL_ADDER_SAT_EN -> 9'h000.
- Backpressure: out_ready=0 after one accepted beat -> in_ready=0, out stays constant for 5 cycles. Release with a new beat pending -> new result next cycle, out_valid continuous.
- Accumulate wrap (ACC_WIDTH=9): 3x ACC lane0 255+255 -> acc sequence 510, 508 with ovf=1, 506 with ovf=1. With SAT_EN -> 510, 511, 511, ovf=1. CLR -> acc=0, ovf=0.
- Streaming: 100 random back-to-back beats, out_ready random 50% -> every accepted beat is produced exactly once, in order, matching the scoreboard.
- Mid-op reset: assert rst while out_valid=1 and acc=0x1234 -> out_valid=0, acc=0 asynchronously; first post-reset beat behaves as fresh.
